lzv_norm: RTL and testbench

//   Leading-zero count and normalize unit for the float datapath (mantissa normalization).
//   - Registers a 24-bit input vector.
//   - Outputs the vector shifted left so its MSB is 1, plus the leading-zero count and a zero flag.
//   - Sits after the mantissa add/sub stage and feeds exponent adjust and rounding.

---
 rtl/lzv_norm.sv | 121 ++++++++++++
 tb/tb_lzv_norm.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lzv_norm.sv
// lzv_norm: leading-zero count and normalize unit for mantissa normalization.
//
// Ports:
//   clk   - single clock, all state updates on posedge
//   rst   - synchronous reset, active-high; clears every register
//   v     - W-bit unsigned value to normalize
//   res   - v shifted left by lzc (MSB is 1 unless v == 0), registered
//   lzc   - number of leading zeros of v (0..W), registered
//   zero  - 1 when v == 0, registered
//
// Build option: define LZV_PIPE2_EN to register the count before the
// barrel shifter (latency 2 instead of 1, throughput still 1 per clock).
module lzv_norm #(
    parameter int W  = 24,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  v,
    output logic [W-1:0]  res,
    output logic [CW-1:0] lzc,
    output logic          zero
);

    // The priority tree works on a power-of-two vector. Padding with zeros
    // below the LSB keeps the count exact for any non-zero v; the all-zero
    // case is caught by the root zero flag and forced to W.
    localparam int P = 1 << CW;

    logic [P-1:0] pad;
    assign pad = {v, {(P - W){1'b0}}};

    // Level gi holds P>>gi nodes; each node carries an all-zero flag and a
    // CW-bit count of leading zeros inside its 2**gi-bit span.
    for (genvar gi = 0; gi <= CW; gi++) begin : g_lvl
        localparam int N = P >> gi;
        logic [N-1:0]    z;
        logic [N*CW-1:0] c;
        if (gi == 0) begin : g_leaf
            assign z = ~pad;
            assign c = '0;
        end else begin : g_node
            localparam logic [CW-1:0] HALF = CW'(1 << (gi - 1));
            for (genvar gj = 0; gj < N; gj++) begin : g_pair
                // Upper child all zero: count continues into the lower child.
                assign z[gj] = g_lvl[gi-1].z[2*gj+1] & g_lvl[gi-1].z[2*gj];
                assign c[gj*CW +: CW] = g_lvl[gi-1].z[2*gj+1]
                                      ? (HALF | g_lvl[gi-1].c[(2*gj)*CW +: CW])
                                      : g_lvl[gi-1].c[(2*gj+1)*CW +: CW];
            end
        end
    end

    logic          all_zero;
    logic [CW-1:0] cnt_comb;
    assign all_zero = g_lvl[CW].z[0];
    assign cnt_comb = all_zero ? CW'(W) : g_lvl[CW].c[CW-1:0];

    // Operands of the barrel shifter, either straight from the input or
    // from the intermediate pipeline stage.
    logic [W-1:0]  sh_in;
    logic [CW-1:0] sh_cnt;
    logic          sh_zero;

`ifdef LZV_PIPE2_EN
    logic [W-1:0]  v_reg;
    logic [CW-1:0] cnt_reg;
    logic          zero_p_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg      <= '0;
            cnt_reg    <= '0;
            zero_p_reg <= 1'b0;
        end else begin
            v_reg      <= v;
            cnt_reg    <= cnt_comb;
            zero_p_reg <= all_zero;
        end
    end

    assign sh_in   = v_reg;
    assign sh_cnt  = cnt_reg;
    assign sh_zero = zero_p_reg;
`else
    assign sh_in   = v;
    assign sh_cnt  = cnt_comb;
    assign sh_zero = all_zero;
`endif

    // Barrel shifter: stage gi shifts by 2**gi when count bit gi is set.
    for (genvar gi = 0; gi < CW; gi++) begin : g_shf
        logic [W-1:0] s;
        if (gi == 0) begin : g_first
            assign s = sh_cnt[0] ? (sh_in << 1) : sh_in;
        end else begin : g_next
            assign s = sh_cnt[gi] ? (g_shf[gi-1].s << (1 << gi)) : g_shf[gi-1].s;
        end
    end

    logic [W-1:0]  res_reg;
    logic [CW-1:0] lzc_reg;
    logic          zero_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg  <= '0;
            lzc_reg  <= '0;
            zero_reg <= 1'b0;
        end else begin
            res_reg  <= g_shf[CW-1].s;
            lzc_reg  <= sh_cnt;
            zero_reg <= sh_zero;
        end
    end

    assign res  = res_reg;
    assign lzc  = lzc_reg;
    assign zero = zero_reg;

endmodule

// File: tb/tb_lzv_norm.sv
// tb_lzv_norm: directed bench for lzv_norm. Inputs change on the falling
// edge; outputs are checked on the falling edge against a linear-scan
// reference model of the input applied LAT cycles earlier, plus
// hand-computed values for the directed vectors.
module tb_lzv_norm;

    localparam int W  = 24;
    localparam int CW = 5;
`ifdef LZV_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  v   = '0;
    logic [W-1:0]  res;
    logic [CW-1:0] lzc;
    logic          zero;

    lzv_norm #(.W(W), .CW(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .v    (v),
        .res  (res),
        .lzc  (lzc),
        .zero (zero)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    logic          h_rst [0:511];
    logic [W-1:0]  h_v   [0:511];
    bit            h_he  [0:511];
    logic [W-1:0]  h_er  [0:511];
    logic [CW-1:0] h_el  [0:511];
    logic          h_ez  [0:511];

    function automatic logic [CW-1:0] m_lzc(input logic [W-1:0] x);
        int  n = 0;
        bit  seen = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) seen = 1'b1;
            if (!seen) n++;
        end
        return CW'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
        end
    endtask

    // One clock: check the outputs that are due, then apply the new input.
    task automatic step(input logic r, input logic [W-1:0] vv, input bit he,
                        input logic [W-1:0] er, input logic [CW-1:0] el, input logic ez);
        bit            any_rst;
        int            src;
        logic [CW-1:0] ml;
        logic [W-1:0]  mr;
        @(negedge clk);
        if (cyc_n >= LAT) begin
            any_rst = 1'b0;
            for (int k = 1; k <= LAT; k++)
                if (h_rst[cyc_n-k]) any_rst = 1'b1;
            src = cyc_n - LAT;
            if (any_rst) begin
                chk("rst_res", 32'(res), 32'd0);
                chk("rst_lzc", 32'(lzc), 32'd0);
                chk("rst_zero", 32'(zero), 32'd0);
            end else begin
                ml = m_lzc(h_v[src]);
                mr = h_v[src] << ml;
                chk("model_res", 32'(res), 32'(mr));
                chk("model_lzc", 32'(lzc), 32'(ml));
                chk("model_zero", 32'(zero), 32'(h_v[src] == '0));
                if (!zero) chk("msb_set", 32'(res[W-1]), 32'd1);
                if (h_he[src]) begin
                    chk("hand_res", 32'(res), 32'(h_er[src]));
                    chk("hand_lzc", 32'(lzc), 32'(h_el[src]));
                    chk("hand_zero", 32'(zero), 32'(h_ez[src]));
                end
            end
        end
        h_rst[cyc_n] = r;
        h_v[cyc_n]   = vv;
        h_he[cyc_n]  = he;
        h_er[cyc_n]  = er;
        h_el[cyc_n]  = el;
        h_ez[cyc_n]  = ez;
        rst = r;
        v   = vv;
        cyc_n++;
    endtask

    initial begin
        // Reset for two clocks, then the directed boundary vectors.
        step(1'b1, 24'h000000, 1'b0, 24'h0, 5'd0, 1'b0);
        step(1'b1, 24'h000000, 1'b0, 24'h0, 5'd0, 1'b0);
        step(1'b0, 24'h000000, 1'b1, 24'h000000, 5'd24, 1'b1);
        step(1'b0, 24'h000001, 1'b1, 24'h800000, 5'd23, 1'b0);
        step(1'b0, 24'h800000, 1'b1, 24'h800000, 5'd0,  1'b0);
        step(1'b0, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 5'd0,  1'b0);
        step(1'b0, 24'h000003, 1'b1, 24'hC00000, 5'd22, 1'b0);
        step(1'b0, 24'h0A5000, 1'b1, 24'hA50000, 5'd4,  1'b0);
        step(1'b0, 24'h000100, 1'b1, 24'h800000, 5'd15, 1'b0);
        step(1'b0, 24'h400000, 1'b1, 24'h800000, 5'd1,  1'b0);

        // Incrementing counter with a single-clock reset in the middle.
        for (int i = 0; i < 250; i++)
            step(i == 120, W'(i), 1'b0, 24'h0, 5'd0, 1'b0);

        // Drain the pipeline.
        for (int i = 0; i <= LAT; i++)
            step(1'b0, 24'h000000, 1'b0, 24'h0, 5'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
